// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Arbitrates two writeback requesters (A: ALU, B: memory/load) onto a single
// register-file write port through a small in-order FIFO.
//
// Parameters:
//   DATA_W  register data width
//   ADDR_W  register index width (2**ADDR_W registers)
//   DEPTH   write-queue entries (power of two, 2..8)
// Ports:
//   clk                      single rising-edge clock
//   rst                      synchronous, active-low reset
//   a_valid/a_rd/a_data      requester A write request
//   a_ready                  A's write is accepted this cycle (combinational)
//   b_valid/b_rd/b_data      requester B write request
//   b_ready                  B's write is accepted this cycle (combinational)
//   hold                     register-file write port unavailable this cycle
//   rf_we/rf_rd/rf_data      registered write to the register file
//   pend                     mask of registers with a queued or presented write
//   q_count                  current queue occupancy
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      a_valid,
    input  logic [ADDR_W-1:0]         a_rd,
    input  logic [DATA_W-1:0]         a_data,
    output logic                      a_ready,
    input  logic                      b_valid,
    input  logic [ADDR_W-1:0]         b_rd,
    input  logic [DATA_W-1:0]         b_data,
    output logic                      b_ready,
    input  logic                      hold,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_rd,
    output logic [DATA_W-1:0]         rf_data,
    output logic [(2**ADDR_W)-1:0]    pend,
    output logic [$clog2(DEPTH):0]    q_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2**ADDR_W;

    logic [ADDR_W-1:0] rd_q_r   [DEPTH];
    logic [DATA_W-1:0] data_q_r [DEPTH];
    logic [DEPTH-1:0]  valid_r;
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    // 1 means B wins the next tie; cleared by reset so A wins first.
    logic              prio_b_r;

    logic              rf_we_r;
    logic [ADDR_W-1:0] rf_rd_r;
    logic [DATA_W-1:0] rf_data_r;

    logic              full_s;
    logic              a_ready_s;
    logic              b_ready_s;
    logic              acc_a_s;
    logic              acc_b_s;
    logic [ADDR_W-1:0] in_rd_s;
    logic [DATA_W-1:0] in_data_s;
    logic              push_s;
    logic              pop_s;
    logic [NREG-1:0]   pend_s;

    // Grant selection: nothing is accepted in reset or when the queue is full,
    // even if the head pops this cycle (keeps the ready path off the hold input).
    always_comb begin
        full_s    = (count_r == CNT_W'(DEPTH));
        a_ready_s = 1'b0;
        b_ready_s = 1'b0;
        if (!rst || full_s) begin
            a_ready_s = 1'b0;
            b_ready_s = 1'b0;
        end else if (a_valid && b_valid) begin
            a_ready_s = !prio_b_r;
            b_ready_s = prio_b_r;
        end else begin
            a_ready_s = a_valid;
            b_ready_s = b_valid;
        end
    end

    // Accepted-transfer decode; writes to r0 are accepted but never queued.
    always_comb begin
        acc_a_s   = a_valid && a_ready_s;
        acc_b_s   = b_valid && b_ready_s;
        in_rd_s   = acc_a_s ? a_rd   : b_rd;
        in_data_s = acc_a_s ? a_data : b_data;
        push_s    = (acc_a_s || acc_b_s) && (in_rd_s != {ADDR_W{1'b0}});
        pop_s     = !hold && (count_r != {CNT_W{1'b0}});
    end

    // Queue pointers, occupancy, per-slot valid bits and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_r   <= {PTR_W{1'b0}};
            tail_r   <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            valid_r  <= {DEPTH{1'b0}};
            prio_b_r <= 1'b0;
        end else begin
            // Push and pop never target the same slot: a push needs a non-full
            // queue and a pop needs a non-empty one, so head != tail when both.
            if (pop_s) begin
                valid_r[head_r] <= 1'b0;
                head_r          <= head_r + PTR_W'(1);
            end
            if (push_s) begin
                valid_r[tail_r] <= 1'b1;
                tail_r          <= tail_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (acc_a_s) begin
                prio_b_r <= 1'b1;
            end else if (acc_b_s) begin
                prio_b_r <= 1'b0;
            end else begin
                prio_b_r <= prio_b_r;
            end
        end
    end

    // Queue payload storage; contents are qualified by valid_r so no reset needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            rd_q_r[tail_r]   <= in_rd_s;
            data_q_r[tail_r] <= in_data_s;
        end
    end

    // Register-file write stage: one-cycle we pulse per pop, index/data hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_we_r   <= 1'b0;
            rf_rd_r   <= {ADDR_W{1'b0}};
            rf_data_r <= {DATA_W{1'b0}};
        end else if (pop_s) begin
            rf_we_r   <= 1'b1;
            rf_rd_r   <= rd_q_r[head_r];
            rf_data_r <= data_q_r[head_r];
        end else begin
            rf_we_r   <= 1'b0;
        end
    end

    // Pending mask over valid queue slots plus the write being presented.
    always_comb begin
        pend_s = {NREG{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            pend_s[rd_q_r[i]] = pend_s[rd_q_r[i]] | valid_r[i];
        end
        pend_s[rf_rd_r] = pend_s[rf_rd_r] | rf_we_r;
        pend_s[0]       = 1'b0;
    end

    assign a_ready = a_ready_s;
    assign b_ready = b_ready_s;
    assign rf_we   = rf_we_r;
    assign rf_rd   = rf_rd_r;
    assign rf_data = rf_data_r;
    assign pend    = pend_s;
    assign q_count = count_r;

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning the register index width (32 registers).
REQ-003 SHALL have parameter DEPTH, default 2, meaning the write-queue entries (power of two, 2..8).
REQ-004 SHALL have port clk  input  1  meaning the single clock; every flop updates on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning the reset, which is synchronous and active-low.
REQ-006 SHALL have port a_valid  input  1  meaning that ALU writeback requester A holds a write.
REQ-007 SHALL have port a_rd  input  ADDR_W  meaning requester A's destination register.
REQ-008 SHALL have port a_data  input  DATA_W  meaning requester A's write data.
REQ-009 SHALL have port a_ready  output  1  meaning that A's write is accepted this cycle.
REQ-010 SHALL have ports b_valid, b_rd, b_data and b_ready, identical to the A ports, for memory/load writeback requester B.
REQ-011 SHALL have port hold  input  1  meaning that the register-file write port is unavailable this cycle.
REQ-012 SHALL have port rf_we  output  1  meaning the registered write enable to the register file (its we).
REQ-013 SHALL have port rf_rd  output  ADDR_W  meaning the registered write index (its rd).
REQ-014 SHALL have port rf_data  output  DATA_W  meaning the registered write data (its dataIn).
REQ-015 SHALL have port pend  output  2**ADDR_W  meaning a mask of registers with a queued or presented write.
REQ-016 SHALL have port q_count  output  clog2(DEPTH)+1  meaning the current queue occupancy.

Function
REQ-017 SHALL perform a transfer on requester X at a rising edge when x_valid and x_ready are both 1.
REQ-018 SHALL generate a_ready and b_ready combinationally; at most one is 1 in any cycle.
REQ-019 SHALL keep both ready outputs at 0 while the queue is full (q_count==DEPTH), even if a pop occurs that cycle.
REQ-020 SHALL grant the only valid requester when just one is valid and the queue is not full.
REQ-021 SHALL grant, when both are valid and the queue is not full, the requester not granted at the last accepted transfer (round-robin).
REQ-022 SHALL update the last-grant pointer only on an accepted transfer; reset selects A as first winner.
REQ-023 SHALL enqueue an accepted transfer with rd!=0 at the tail of the FIFO queue.
REQ-024 SHALL accept and discard a transfer with rd==0 without enqueuing it (the pointer still updates).
REQ-025 SHALL pop the head when hold==0 and q_count>0, registering rf_we=1, rf_rd and rf_data for exactly the next cycle.
REQ-026 SHALL drive rf_we=0 the cycle after any edge with no pop; rf_rd and rf_data then hold their last values.
REQ-027 SHALL allow a push and a pop at the same edge, with q_count unchanged.
REQ-028 SHALL have a minimum latency of 2 edges: accepted at edge T into an empty queue with hold=0, the write appears with rf_we=1 after edge T+1.
REQ-029 SHALL issue writes to the register file strictly in acceptance order.
REQ-030 SHALL serialize same-cycle requests to the same rd in grant order, so the later grant's data wins.
REQ-031 SHALL never drop an accepted rd!=0 write: hold of any length only stalls the queue, and a full queue backpressures via ready.
REQ-032 SHALL set pend bit i when any valid queue entry has rd==i, or when rf_we==1 and rf_rd==i; pend is combinational and pend[0] is always 0.

Reset
REQ-033 SHALL, when rst==0 at an edge, empty the queue (q_count=0), clear rf_we, rf_rd and rf_data to 0, and point round-robin at A.
REQ-034 SHALL hold a_ready and b_ready at 0 while rst==0, so no transfer is accepted during reset.
REQ-035 SHALL have pend=0 the cycle after reset.
REQ-036 SHALL discard queued writes when reset occurs mid-operation, with no rf_we pulse after the reset edge.

Verification
REQ-037 SHALL cover single write: A writes rd=1, data=2001, with hold=0 -> a_ready=1, and two edges later rf_we=1, rf_rd=1, rf_data=2001 for one cycle; pend[1]=1 until rf_we falls.
REQ-038 SHALL cover contention: A (rd=2, 4001) and B (rd=6, 8002) both held valid for 2 cycles after reset -> A is granted first, then B; rf writes occur in order rd=2 then rd=6 on consecutive cycles.
REQ-039 SHALL cover backpressure: hold=1 with DEPTH=2 and three A writes (rd=8, 9, 10) -> the third waits with a_ready=0 and q_count=2; releasing hold gives writes 8, 9, 10 in order.
REQ-040 SHALL cover r0: B writes rd=0, data=3002 -> b_ready=1, q_count stays 0, no rf_we pulse and pend=0; the next tie is granted to A.
REQ-041 SHALL cover mid-operation reset: two entries queued with hold=1, then rst=0 for one edge -> q_count=0, rf_we=0 and pend=0; releasing hold produces no writes.
REQ-042 SHALL cover simultaneous push and pop: q_count=1 with hold=0 and a new A write -> q_count stays 1 and rf_we pulses each cycle.
